// File: rtl/ap_pkg.sv
// ---------------------------------------------------------------------------
// ap_pkg
// Shared definitions for the multi-precision ALU sequencer.
//   - op encodings seen on the sequencer 'op' port (the same numbering as the
//     8-bit ALU opcode for the logic operations)
//   - sequencer state encoding
//   - arithmetic/logic classification helper
// ---------------------------------------------------------------------------
package ap_pkg;

  localparam logic [2:0] AOP_ADD  = 3'b000;
  localparam logic [2:0] AOP_SUB  = 3'b001;
  localparam logic [2:0] AOP_RSUB = 3'b010;
  localparam logic [2:0] AOP_OR   = 3'b011;
  localparam logic [2:0] AOP_AND  = 3'b100;
  localparam logic [2:0] AOP_ANDN = 3'b101;
  localparam logic [2:0] AOP_XOR  = 3'b110;
  localparam logic [2:0] AOP_XNOR = 3'b111;

  // Bit n is set when op code n is arithmetic (add, sub, rsub). Arithmetic
  // ops chain a carry through the bytes; logic ops are byte-independent.
  localparam logic [7:0] AOP_ARITH_MASK = 8'b0000_0111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } seq_state_t;

  function automatic logic is_arith(input logic [2:0] op);
    return AOP_ARITH_MASK[op];
  endfunction

endpackage

// File: rtl/ap_mp_sequencer.sv
// ---------------------------------------------------------------------------
// ap_mp_sequencer
// Runs one NBYTES-wide operation through an external 8-bit ALU, one byte per
// clock, least-significant byte first, chaining the carry between bytes. It
// assembles the wide result and the final C/V/N/Z flags.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start               operation request, honoured only when idle
//   op                  operation code (see ap_pkg)
//   opa, opb, cin_in    operands and add carry-in, sampled on accept
//   busy                high for the NBYTES byte-processing cycles
//   done                one-cycle pulse, result and flags valid
//   result              wide result, held until the next accept
//   flag_c/v/n/z        final flags, held until the next accept
//   alu_a, alu_b        ALU operand bytes (this block is their only driver)
//   alu_aop, alu_cin    ALU opcode and carry-in
//   alu_f               ALU result byte (combinational from alu_* outputs)
//   alu_cout/ovf/n/z    ALU flags for the current byte
// ---------------------------------------------------------------------------
module ap_mp_sequencer
  import ap_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter int CNT_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [8*NBYTES-1:0]   opa,
  input  logic [8*NBYTES-1:0]   opb,
  input  logic                  cin_in,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  flag_c,
  output logic                  flag_v,
  output logic                  flag_n,
  output logic                  flag_z,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic [2:0]            alu_aop,
  output logic                  alu_cin,
  input  logic [7:0]            alu_f,
  input  logic                  alu_cout,
  input  logic                  alu_ovf,
  input  logic                  alu_n,
  input  logic                  alu_z
);

  localparam int W = 8 * NBYTES;

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [W-1:0]     sa;
  logic [W-1:0]     sb;
  logic [2:0]       opr;
  logic             carry;
  logic             zacc;
  logic [CNT_W-1:0] idx;
  logic             last_byte;
  logic             arith;

  assign last_byte = (idx == CNT_W'(NBYTES - 1));
  assign arith     = is_arith(opr);

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and ALU drive. The ALU's own sub/rsub negate each byte
  // separately and cannot chain a borrow, so subtraction is issued as an add
  // of the inverted operand with the carry register seeded to 1.
  always_comb begin
    state_nxt = state;
    alu_a     = 8'h00;
    alu_b     = 8'h00;
    alu_aop   = AOP_ADD;
    alu_cin   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (arith) begin
          alu_aop = AOP_ADD;
          alu_a   = (opr == AOP_RSUB) ? ~sa[7:0] : sa[7:0];
          alu_b   = (opr == AOP_SUB)  ? ~sb[7:0] : sb[7:0];
          alu_cin = carry;
        end else begin
          alu_aop = opr;
          alu_a   = sa[7:0];
          alu_b   = sb[7:0];
          alu_cin = 1'b0;
        end
        if (last_byte) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath. On accept the operands are captured into shift registers so the
  // low byte always sits at [7:0]. Every RUN cycle consumes one byte and the
  // ALU byte enters the top of result, so after NBYTES cycles the first byte
  // has walked down to [7:0]. Flags are captured only on the last byte so
  // they stay stable (previous operation's values) while the run is in
  // progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      opr    <= AOP_ADD;
      carry  <= 1'b0;
      zacc   <= 1'b0;
      idx    <= '0;
      result <= '0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sa   <= opa;
            sb   <= opb;
            opr  <= op;
            zacc <= 1'b1;
            idx  <= '0;
            if (op == AOP_ADD) begin
              carry <= cin_in;
            end else if ((op == AOP_SUB) || (op == AOP_RSUB)) begin
              carry <= 1'b1;
            end else begin
              carry <= 1'b0;
            end
          end
        end
        S_RUN: begin
          result <= {alu_f, result[W-1:8]};
          sa     <= {8'h00, sa[W-1:8]};
          sb     <= {8'h00, sb[W-1:8]};
          carry  <= alu_cout;
          zacc   <= zacc & alu_z;
          idx    <= idx + CNT_W'(1);
          if (last_byte) begin
            flag_c <= arith & alu_cout;
            flag_v <= arith & alu_ovf;
            flag_n <= alu_n;
            flag_z <= zacc & alu_z;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ap_mp_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ap_mp_sequencer
// Self-checking bench for ap_mp_sequencer (NBYTES=4). Contains a behavioural
// 8-bit ALU hooked to the alu_* ports, a table of hand-derived vectors, a few
// multi-cycle corner sequences, and randomized operations checked against a
// whole-word reference model.
// ---------------------------------------------------------------------------
module tb_ap_mp_sequencer;
  import ap_pkg::*;

  localparam int NB = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        cin_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        flag_c;
  logic        flag_v;
  logic        flag_n;
  logic        flag_z;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_aop;
  logic        alu_cin;
  logic [7:0]  alu_f;
  logic        alu_cout;
  logic        alu_ovf;
  logic        alu_n;
  logic        alu_z;

  logic [8:0]  alu_sum;
  logic        noise;

  int checks;
  int failures;

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        v;
    logic        n;
    logic        z;
  } ref_t;

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    ref_t        exp;
  } vec_t;

  vec_t vecs[12];
  ref_t prevFlags;

  ap_mp_sequencer #(.NBYTES(NB), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .cin_in(cin_in), .busy(busy), .done(done), .result(result),
    .flag_c(flag_c), .flag_v(flag_v), .flag_n(flag_n), .flag_z(flag_z),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aop(alu_aop), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_cout(alu_cout), .alu_ovf(alu_ovf), .alu_n(alu_n),
    .alu_z(alu_z)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Random bit that feeds the ALU carry/overflow outputs whenever they are
  // meaningless (logic ops), so the sequencer must actively mask them.
  always @(negedge clk) noise <= 1'($urandom_range(0, 1));

  // Behavioural 8-bit ALU; only add and the logic ops are ever requested.
  always_comb begin
    alu_sum  = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
    alu_f    = 8'h00;
    alu_cout = noise;
    alu_ovf  = noise;
    case (alu_aop)
      3'b000: begin
        alu_f    = alu_sum[7:0];
        alu_cout = alu_sum[8];
        alu_ovf  = (alu_a[7] == alu_b[7]) && (alu_sum[7] != alu_a[7]);
      end
      3'b011:  alu_f = alu_a | alu_b;
      3'b100:  alu_f = alu_a & alu_b;
      3'b101:  alu_f = ~alu_a & alu_b;
      3'b110:  alu_f = alu_a ^ alu_b;
      3'b111:  alu_f = ~(alu_a ^ alu_b);
      default: alu_f = 8'h00;
    endcase
    alu_n = alu_f[7];
    alu_z = (alu_f == 8'h00);
  end

  // Whole-word reference: plain 32-bit arithmetic, C = no borrow for subs.
  function automatic ref_t refOp(input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic ci);
    ref_t        t;
    logic [32:0] w;
    t = '0;
    case (o)
      3'd0: begin
        w   = {1'b0, a} + {1'b0, b} + {32'd0, ci};
        t.r = w[31:0];
        t.c = w[32];
        t.v = (a[31] == b[31]) && (t.r[31] != a[31]);
      end
      3'd1: begin
        t.r = a - b;
        t.c = (a >= b);
        t.v = (a[31] != b[31]) && (t.r[31] != a[31]);
      end
      3'd2: begin
        t.r = b - a;
        t.c = (b >= a);
        t.v = (a[31] != b[31]) && (t.r[31] != b[31]);
      end
      3'd3:    t.r = a | b;
      3'd4:    t.r = a & b;
      3'd5:    t.r = ~a & b;
      3'd6:    t.r = a ^ b;
      default: t.r = ~(a ^ b);
    endcase
    t.n = t.r[31];
    t.z = (t.r == 32'd0);
    return t;
  endfunction

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Issues one operation and follows it cycle by cycle: busy/done timing,
  // the ALU drive of every byte, flags held during the run, and the final
  // result. With repulse set, start is re-asserted during RUN and DONE.
  task automatic applyStimulus(input string tag, input logic [2:0] o,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic ci, input ref_t exp,
                               input bit repulse);
    logic [31:0] ea;
    logic [31:0] eb;
    logic        c0;
    logic        ar;
    logic [63:0] mask;
    logic [63:0] s;
    logic        ecin;
    ar = (o <= 3'd2);
    ea = (o == 3'd2) ? ~a : a;
    eb = (o == 3'd1) ? ~b : b;
    c0 = (o == 3'd0) ? ci : ar;
    @(negedge clk);
    op = o; opa = a; opb = b; cin_in = ci; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      start = repulse && (k >= 1);
      opa = $urandom; opb = $urandom; op = 3'($urandom_range(0, 7));
      mask = (64'd1 << (8 * k)) - 64'd1;
      s = ({32'd0, ea} & mask) + ({32'd0, eb} & mask) + {63'd0, c0};
      ecin = ar ? s[8 * k] : 1'b0;
      checkOutput($sformatf("%s.busy%0d", tag, k), busy, 1);
      checkOutput($sformatf("%s.done%0d", tag, k), done, 0);
      checkOutput($sformatf("%s.aop%0d", tag, k), alu_aop, ar ? 3'd0 : o);
      checkOutput($sformatf("%s.alua%0d", tag, k), alu_a, ea[8*k +: 8]);
      checkOutput($sformatf("%s.alub%0d", tag, k), alu_b, eb[8*k +: 8]);
      checkOutput($sformatf("%s.alucin%0d", tag, k), alu_cin, ecin);
      checkOutput($sformatf("%s.heldflags%0d", tag, k),
                  {flag_c, flag_v, flag_n, flag_z},
                  {prevFlags.c, prevFlags.v, prevFlags.n, prevFlags.z});
    end
    @(negedge clk);
    start = repulse;
    checkOutput({tag, ".done"}, done, 1);
    checkOutput({tag, ".busyoff"}, busy, 0);
    checkOutput({tag, ".result"}, result, exp.r);
    checkOutput({tag, ".flags"}, {flag_c, flag_v, flag_n, flag_z},
                {exp.c, exp.v, exp.n, exp.z});
    checkOutput({tag, ".aluidle"}, {alu_a, alu_b, alu_aop, alu_cin}, 0);
    prevFlags = exp;
    if (repulse) begin
      @(negedge clk);
      start = 1'b0;
      checkOutput({tag, ".ignbusy"}, busy, 0);
      checkOutput({tag, ".igndone"}, done, 0);
      checkOutput({tag, ".keepres"}, result, exp.r);
    end
  endtask

  // Reset asserted in the second RUN cycle must abort with no done pulse.
  task automatic resetMidRun();
    int doneSeen;
    @(negedge clk);
    op = AOP_ADD; opa = 32'h1234_5678; opb = 32'h1111_1111; cin_in = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst.busy", busy, 0);
    checkOutput("rst.done", done, 0);
    checkOutput("rst.result", result, 0);
    checkOutput("rst.flags", {flag_c, flag_v, flag_n, flag_z}, 0);
    checkOutput("rst.aluidle", {alu_a, alu_b, alu_aop, alu_cin}, 0);
    doneSeen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("rst.nodone", doneSeen, 0);
    prevFlags = '0;
  endtask

  // Main sequence: reset state, vector table, corner sequences, random ops.
  initial begin
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    checks = 0;
    failures = 0;
    prevFlags = '0;
    rst = 1'b1; start = 1'b0; op = 3'd0; opa = '0; opb = '0; cin_in = 1'b0;

    vecs[0]  = '{AOP_ADD,  32'h00FF_FFFF, 32'h0000_0001, 1'b0, '{32'h0100_0000, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[1]  = '{AOP_SUB,  32'h0000_0000, 32'h0000_0001, 1'b0, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[2]  = '{AOP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0}};
    vecs[3]  = '{AOP_ADD,  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, '{32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1}};
    vecs[4]  = '{AOP_RSUB, 32'h0000_0005, 32'h0000_0005, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1}};
    vecs[5]  = '{AOP_XOR,  32'hA5A5_0000, 32'hA5A5_0000, 1'b0, '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[6]  = '{AOP_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, '{32'h00F0_00F0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[7]  = '{AOP_OR,   32'h1234_0000, 32'h0000_5678, 1'b1, '{32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[8]  = '{AOP_ANDN, 32'hFFFF_0000, 32'h1234_5678, 1'b0, '{32'h0000_5678, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[9]  = '{AOP_XNOR, 32'h0000_0000, 32'h0000_0000, 1'b0, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[10] = '{AOP_SUB,  32'h8000_0000, 32'h0000_0001, 1'b0, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[11] = '{AOP_RSUB, 32'h0000_0001, 32'h0000_0000, 1'b1, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0}};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.done", done, 0);
    checkOutput("reset.result", result, 0);
    checkOutput("reset.flags", {flag_c, flag_v, flag_n, flag_z}, 0);
    checkOutput("reset.aluidle", {alu_a, alu_b, alu_aop, alu_cin}, 0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].o, vecs[i].a, vecs[i].b,
                    vecs[i].ci, vecs[i].exp, 1'b0);
    end

    applyStimulus("repulse", AOP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0,
                  refOp(AOP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0), 1'b1);
    applyStimulus("b2b", AOP_ADD, 32'h0000_00FF, 32'h0000_0001, 1'b0,
                  refOp(AOP_ADD, 32'h0000_00FF, 32'h0000_0001, 1'b0), 1'b0);
    applyStimulus("prerst", AOP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0,
                  refOp(AOP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0), 1'b0);
    resetMidRun();

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: ra = 32'h0000_0000;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h7FFF_FFFF;
        3: rb = ra;
        default: ;
      endcase
      applyStimulus($sformatf("rnd%0d", i), ro, ra, rb, rc,
                    refOp(ro, ra, rb, rc), (i % 7) == 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
